sprite_engine: RTL and testbench
================================

# sprite_engine

Pipelined sprite compositor for the GPU: for each streamed screen coordinate it finds the highest-priority sprite covering that pixel and fetches the texel from texture memory. It applies colour-key transparency and emits the resulting colour, or the background colour. It is the parametrised successor of the combinational single-cluster lookup. It adds double-buffered sprite attributes, per-texture selection, fixed priority, a registered memory interface and valid/ready backpressure. It sits between the pixel-coordinate generator and the VGA output stage.

## Interface

Parameters:
- SPRITES, 10: number of sprite slots; slot 0 has the highest priority.
- SPR_W, 16: sprite width in pixels.
- SPR_H, 16: sprite height in pixels.
- COORD_WIDTH, 16: screen coordinate width, unsigned.
- TEX_WIDTH, 4: texture-select field width.
- INDEX_WIDTH, 32: texture memory address width.
- COLOR_WIDTH, 12: colour width, RGB444.
- BG_COLOR, all ones: colour output when no sprite hits.
- KEY_COLOR, 12'hF0F: transparent colour key.

Ports:
- clk  in  1  clock; one clock domain. Reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  write the shadow attributes of slot cfg_sel.
- cfg_sel  in  $clog2(SPRITES)  slot select.
- cfg_x, cfg_y  in  COORD_WIDTH  sprite top-left corner.
- cfg_tex  in  TEX_WIDTH  texture number.
- cfg_en  in  1  sprite enable.
- commit  in  1  copy all shadow attributes to active in one cycle (frame boundary).
- in_valid  in  1  coordinate valid.
- in_ready  out  1  coordinate accepted when in_valid && in_ready.
- in_x, in_y  in  COORD_WIDTH  pixel coordinate.
- out_valid  out  1  colour valid.
- out_ready  in  1  downstream accepts.
- out_color  out  COLOR_WIDTH  composited colour.
- mem_en  out  1  texture RAM read enable.
- mem_addr  out  INDEX_WIDTH  texture RAM address.
- mem_color  in  COLOR_WIDTH  synchronous RAM data, 1-cycle read latency.

## Operation

- Hit for slot k: en_k && sx_k <= in_x < sx_k+SPR_W && sy_k <= in_y < sy_k+SPR_H.
  - Compare at COORD_WIDTH+1 bits so that sx+SPR_W never wraps.
  - A sprite partially off the right or bottom edge clips; it does not wrap to the left or top.
- Priority: the lowest hitting index wins; no hit selects the background.
- Address: tex_k*SPR_W*SPR_H + (in_y-sy_k)*SPR_W + (in_x-sx_k), zero-extended, then truncated to INDEX_WIDTH.
- Pipeline:
  - S1 registers valid1, hit1 and addr on acceptance.
  - mem_addr = addr; mem_en = advance.
  - S2 registers valid2 and hit2, aligned with mem_color.
  - out_color = hit2 && mem_color != KEY_COLOR ? mem_color : BG_COLOR (combinational from S2).
- Handshake:
  - advance = !valid2 || out_ready; in_ready = advance.
  - All stage registers update only on advance.
  - With mem_en low the RAM holds its output, so out_color is stable while stalled.
- Attributes:
  - cfg_we writes the shadow copy only.
  - commit copies every shadow slot to active.
  - cfg_we and commit in the same cycle: active receives the old shadow value; the new value stays in shadow until the next commit.

## Timing

- Latency: coordinate accepted at cycle t gives out_valid at t+2 with no stall.
- Throughput: 1 pixel per cycle.
- Commit at cycle t affects coordinates accepted at t+1 onward. Pixels already in flight keep the attributes they were tested with.
- Reset values:
  - valid1, valid2, out_valid: 0.
  - hit flags: 0; mem_addr: 0.
  - All shadow and active attributes: 0, so every sprite is disabled.
  - in_ready: 1; mem_en: 1; out_color: BG_COLOR.
- Reset mid-stream discards in-flight pixels; nothing is emitted for them.

## Configuration

- SPRITE_ENGINE_TRANSPARENCY_EN defined: the KEY_COLOR comparison is active.
- Undefined: every hit is opaque and out_color = hit2 ? mem_color : BG_COLOR. The KEY_COLOR parameter is ignored.

## Structure

- Package gpu_pkg holds:
  - typedef sprite_attr_t (x, y, tex, en);
  - default SPR_W and SPR_H;
  - the RGB444 colour typedef.
- Sub-module sprite_hit:
  - one instance per slot;
  - combinational in-bounds test plus local offset;
  - outputs hit and offset.
- The top level does the priority encode, the pipeline and the attribute banks.

## Test plan

- Reset, no commit, stream (5,5) -> out_color BG_COLOR at t+2; mem_en high; out_valid one cycle per accepted pixel.
- Slot 3 at (10,20), tex 2, commit; stream (10,20), (25,35), (26,20):
  - (10,20) -> mem_addr 512;
  - (25,35) -> mem_addr 767;
  - (26,20) -> BG.
- Slots 1 and 4 overlap at (0,0) -> address taken from slot 1. Disable slot 1 and commit -> address from slot 4.
- mem_color 12'hF0F on a hit -> BG_COLOR with the macro defined; 12'hF0F without it.
- Hold out_ready low 3 cycles with a full pipeline -> in_ready low, mem_en low, out_color and out_valid stable. Release -> no pixel is lost or duplicated.
- cfg_we slot 0 x=50 in the same cycle as commit -> active x is the old value. The next commit makes x=50 active.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU types: the sprite attribute record, default sprite size and the RGB444 colour.
package gpu_pkg;

    localparam int SPR_W_DEF       = 16;
    localparam int SPR_H_DEF       = 16;
    localparam int COORD_WIDTH_DEF = 16;
    localparam int TEX_WIDTH_DEF   = 4;

    typedef logic [11:0] rgb444_t;

    typedef struct packed {
        logic [COORD_WIDTH_DEF-1:0] x;
        logic [COORD_WIDTH_DEF-1:0] y;
        logic [TEX_WIDTH_DEF-1:0]   tex;
        logic                       en;
    } sprite_attr_t;

endpackage

// File: rtl/sprite_hit.sv
// Per-slot in-bounds test of a pixel against one sprite rectangle, plus the
// pixel's offset within that sprite's texture (row-major, SPR_W texels per row).
module sprite_hit
    import gpu_pkg::*;
#(
    parameter int COORD_WIDTH = COORD_WIDTH_DEF,
    parameter int SPR_W       = SPR_W_DEF,
    parameter int SPR_H       = SPR_H_DEF,
    parameter int OFF_WIDTH   = $clog2(SPR_W * SPR_H)
) (
    input  logic                   en_i,
    input  logic [COORD_WIDTH-1:0] sx_i,
    input  logic [COORD_WIDTH-1:0] sy_i,
    input  logic [COORD_WIDTH-1:0] px_i,
    input  logic [COORD_WIDTH-1:0] py_i,
    output logic                   hit_o,
    output logic [OFF_WIDTH-1:0]   off_o
);

    localparam int CW1 = COORD_WIDTH + 1;

    logic [CW1-1:0]         px_w, py_w, sx_w, sy_w;
    logic [COORD_WIDTH-1:0] dx, dy;
    logic [31:0]            off_full;

    always_comb begin
        // One extra bit so a sprite near the far edge clips instead of wrapping.
        px_w  = {1'b0, px_i};
        py_w  = {1'b0, py_i};
        sx_w  = {1'b0, sx_i};
        sy_w  = {1'b0, sy_i};
        hit_o = en_i
             && (px_w >= sx_w) && (px_w < sx_w + CW1'(SPR_W))
             && (py_w >= sy_w) && (py_w < sy_w + CW1'(SPR_H));
        dx       = px_i - sx_i;
        dy       = py_i - sy_i;
        off_full = 32'(dy) * 32'(SPR_W) + 32'(dx);
        off_o    = OFF_WIDTH'(off_full);
    end

endmodule

// File: rtl/sprite_engine.sv
// Two-stage sprite compositor with double-buffered attributes and valid/ready flow.
// Colour-key transparency is compiled in with SPRITE_ENGINE_TRANSPARENCY_EN.
module sprite_engine
    import gpu_pkg::*;
#(
    parameter int SPRITES     = 10,
    parameter int SPR_W       = SPR_W_DEF,
    parameter int SPR_H       = SPR_H_DEF,
    parameter int COORD_WIDTH = COORD_WIDTH_DEF,
    parameter int TEX_WIDTH   = TEX_WIDTH_DEF,
    parameter int INDEX_WIDTH = 32,
    parameter int COLOR_WIDTH = 12,
    parameter logic [COLOR_WIDTH-1:0] BG_COLOR  = '1,
    parameter logic [COLOR_WIDTH-1:0] KEY_COLOR = COLOR_WIDTH'(12'hF0F)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [$clog2(SPRITES)-1:0]   cfg_sel,
    input  logic [COORD_WIDTH-1:0]       cfg_x,
    input  logic [COORD_WIDTH-1:0]       cfg_y,
    input  logic [TEX_WIDTH-1:0]         cfg_tex,
    input  logic                         cfg_en,
    input  logic                         commit,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [COORD_WIDTH-1:0]       in_x,
    input  logic [COORD_WIDTH-1:0]       in_y,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [COLOR_WIDTH-1:0]       out_color,
    output logic                         mem_en,
    output logic [INDEX_WIDTH-1:0]       mem_addr,
    input  logic [COLOR_WIDTH-1:0]       mem_color
);

    localparam int SEL_W     = $clog2(SPRITES);
    localparam int OFF_WIDTH = $clog2(SPR_W * SPR_H);

`ifdef SPRITE_ENGINE_TRANSPARENCY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    typedef struct packed {
        logic [COORD_WIDTH-1:0] x;
        logic [COORD_WIDTH-1:0] y;
        logic [TEX_WIDTH-1:0]   tex;
        logic                   en;
    } attr_t;

    attr_t shadow_q [SPRITES];
    attr_t active_q [SPRITES];

    logic [SPRITES-1:0]   hit_vec;
    logic [OFF_WIDTH-1:0] off_arr [SPRITES];

    logic                   hit_d;
    logic [OFF_WIDTH-1:0]   win_off;
    logic [TEX_WIDTH-1:0]   win_tex;
    logic [INDEX_WIDTH-1:0] addr_d;

    logic                   valid1_q, hit1_q, valid2_q, hit2_q;
    logic [INDEX_WIDTH-1:0] addr_q;
    logic                   advance;

    // Commit reads the pre-edge shadow, so a same-cycle cfg_we waits for the next commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SPRITES; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SPRITES; i++) begin
                if (cfg_we && cfg_sel == SEL_W'(i)) begin
                    shadow_q[i] <= '{x: cfg_x, y: cfg_y, tex: cfg_tex, en: cfg_en};
                end
                if (commit) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    for (genvar gi = 0; gi < SPRITES; gi++) begin : g_slot
        sprite_hit #(
            .COORD_WIDTH (COORD_WIDTH),
            .SPR_W       (SPR_W),
            .SPR_H       (SPR_H),
            .OFF_WIDTH   (OFF_WIDTH)
        ) u_hit (
            .en_i  (active_q[gi].en),
            .sx_i  (active_q[gi].x),
            .sy_i  (active_q[gi].y),
            .px_i  (in_x),
            .py_i  (in_y),
            .hit_o (hit_vec[gi]),
            .off_o (off_arr[gi])
        );
    end

    // Scan from the lowest priority upward so the lowest hitting slot is the last write.
    always_comb begin
        hit_d   = 1'b0;
        win_off = '0;
        win_tex = '0;
        for (int i = SPRITES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_d   = 1'b1;
                win_off = off_arr[i];
                win_tex = active_q[i].tex;
            end
        end
        addr_d = hit_d ? INDEX_WIDTH'(64'(win_tex) * 64'(SPR_W * SPR_H) + 64'(win_off)) : '0;
    end

    assign advance = !valid2_q || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid1_q <= 1'b0;
            hit1_q   <= 1'b0;
            addr_q   <= '0;
            valid2_q <= 1'b0;
            hit2_q   <= 1'b0;
        end else if (advance) begin
            valid1_q <= in_valid;
            hit1_q   <= hit_d;
            addr_q   <= addr_d;
            valid2_q <= valid1_q;
            hit2_q   <= hit1_q;
        end
    end

    // mem_en doubles as the stall: a held RAM output keeps out_color steady.
    assign in_ready  = advance;
    assign mem_en    = advance;
    assign mem_addr  = addr_q;
    assign out_valid = valid2_q;
    assign out_color = (hit2_q && !(KEY_EN && mem_color == KEY_COLOR)) ? mem_color : BG_COLOR;

endmodule

// File: tb/tb_sprite_engine.sv
// Directed bench for sprite_engine with a 1-cycle synchronous texture RAM model.
module tb_sprite_engine;

`ifdef SPRITE_ENGINE_TRANSPARENCY_EN
    localparam logic [11:0] KEY_RESULT = 12'hFFF;
`else
    localparam logic [11:0] KEY_RESULT = 12'hF0F;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_sel = '0;
    logic [15:0] cfg_x = '0;
    logic [15:0] cfg_y = '0;
    logic [3:0]  cfg_tex = '0;
    logic        cfg_en = 1'b0;
    logic        commit = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = '0;
    logic [15:0] in_y = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_color;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [11:0] mem_color = '0;

    logic [11:0] ram [4096];

    int tests = 0;
    int fails = 0;

    sprite_engine dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_x     (cfg_x),
        .cfg_y     (cfg_y),
        .cfg_tex   (cfg_tex),
        .cfg_en    (cfg_en),
        .commit    (commit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_color (out_color),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_color (mem_color)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) mem_color <= ram[mem_addr[11:0]];
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [3:0] sel, input logic [15:0] x, input logic [15:0] y,
                             input logic [3:0] tex, input logic en, input logic with_commit);
        cfg_we = 1'b1; cfg_sel = sel; cfg_x = x; cfg_y = y; cfg_tex = tex; cfg_en = en;
        commit = with_commit;
        cycle();
        cfg_we = 1'b0; commit = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        cycle();
        commit = 1'b0;
    endtask

    // Send one pixel, check the address one cycle later and the colour two cycles later.
    task automatic probe(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input bit exp_hit, input logic [31:0] exp_addr, input logic [11:0] exp_color);
        in_valid = 1'b1; in_x = x; in_y = y;
        cycle();
        in_valid = 1'b0;
        if (exp_hit) check({tag, ".addr"}, 64'(mem_addr), 64'(exp_addr));
        cycle();
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".color"}, 64'(out_color), 64'(exp_color));
        $display("[TB] pixel %s (%0d,%0d) addr=%0d color=%03h", tag, x, y, mem_addr, out_color);
        cycle();
        check({tag, ".drain"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) ram[a] = 12'(a);
        ram[1316] = 12'hF0F;

        repeat (2) cycle();
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.mem_en", 64'(mem_en), 64'd1);
        check("rst.mem_addr", 64'(mem_addr), 64'd0);
        check("rst.out_color", 64'(out_color), 64'hFFF);
        rst = 1'b0;
        cycle();

        in_valid = 1'b1; in_x = 16'd5; in_y = 16'd5;
        cycle();
        in_valid = 1'b0;
        check("bg.early", 64'(out_valid), 64'd0);
        check("bg.mem_en", 64'(mem_en), 64'd1);
        cycle();
        check("bg.valid", 64'(out_valid), 64'd1);
        check("bg.color", 64'(out_color), 64'hFFF);
        cycle();
        check("bg.once", 64'(out_valid), 64'd0);

        cfg_write(4'd3, 16'd10, 16'd20, 4'd2, 1'b1, 1'b0);
        do_commit();
        probe("s3.corner", 16'd10, 16'd20, 1'b1, 32'd512, 12'h200);
        probe("s3.far", 16'd25, 16'd35, 1'b1, 32'd767, 12'h2FF);
        probe("s3.right", 16'd26, 16'd20, 1'b0, 32'd0, 12'hFFF);
        probe("s3.below", 16'd25, 16'd36, 1'b0, 32'd0, 12'hFFF);

        cfg_write(4'd1, 16'd0, 16'd0, 4'd1, 1'b1, 1'b0);
        cfg_write(4'd4, 16'd0, 16'd0, 4'd5, 1'b1, 1'b0);
        do_commit();
        probe("prio.s1", 16'd3, 16'd2, 1'b1, 32'd291, 12'h123);
        cfg_write(4'd1, 16'd0, 16'd0, 4'd1, 1'b0, 1'b0);
        do_commit();
        probe("prio.s4", 16'd3, 16'd2, 1'b1, 32'd1315, 12'h523);

        probe("key", 16'd4, 16'd2, 1'b1, 32'd1316, KEY_RESULT);

        in_valid = 1'b1; in_x = 16'd0; in_y = 16'd0;
        cycle();
        in_x = 16'd1;
        cycle();
        out_ready = 1'b0;
        in_x = 16'd2;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("stall.in_ready", 64'(in_ready), 64'd0);
            check("stall.mem_en", 64'(mem_en), 64'd0);
            check("stall.valid", 64'(out_valid), 64'd1);
            check("stall.color", 64'(out_color), 64'h500);
            check("stall.addr", 64'(mem_addr), 64'd1281);
            $display("[TB] stall step %0d color=%03h in_ready=%0b", k, out_color, in_ready);
            if (k < 3) cycle();
        end
        out_ready = 1'b1;
        #1;
        check("release.in_ready", 64'(in_ready), 64'd1);
        cycle();
        check("release.b.valid", 64'(out_valid), 64'd1);
        check("release.b.color", 64'(out_color), 64'h501);
        in_x = 16'd5; in_y = 16'd1;
        cycle();
        in_valid = 1'b0;
        check("release.c.color", 64'(out_color), 64'h502);
        cycle();
        check("release.d.valid", 64'(out_valid), 64'd1);
        check("release.d.color", 64'(out_color), 64'h515);
        cycle();
        check("release.empty", 64'(out_valid), 64'd0);
        $display("[TB] stall release sequence done");

        cfg_write(4'd0, 16'd30, 16'd100, 4'd3, 1'b1, 1'b0);
        do_commit();
        cfg_write(4'd0, 16'd50, 16'd100, 4'd3, 1'b1, 1'b1);
        probe("wc.old_x", 16'd30, 16'd100, 1'b1, 32'd768, 12'h300);
        probe("wc.new_miss", 16'd50, 16'd100, 1'b0, 32'd0, 12'hFFF);
        do_commit();
        probe("wc.new_x", 16'd50, 16'd100, 1'b1, 32'd768, 12'h300);
        probe("wc.old_gone", 16'd30, 16'd100, 1'b0, 32'd0, 12'hFFF);

        in_valid = 1'b1; in_x = 16'd0; in_y = 16'd0;
        cycle();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst.valid", 64'(out_valid), 64'd0);
        check("midrst.addr", 64'(mem_addr), 64'd0);
        cycle();
        rst = 1'b0;
        cycle();
        check("midrst.after1", 64'(out_valid), 64'd0);
        cycle();
        check("midrst.after2", 64'(out_valid), 64'd0);
        probe("midrst.cleared", 16'd0, 16'd0, 1'b0, 32'd0, 12'hFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
